// File: rtl/sprite_blit_writer.sv
// sprite_blit_writer
//   Copies a W x H rectangle of palette indices from a combinational sprite
//   ROM into a framebuffer write port, one pixel per clock, raster order.
//   Pixels that land outside the FB_WIDTH x FB_HEIGHT framebuffer still take
//   their cycle but are not written.
//
//   Optional feature macro: BLIT_TRANSPARENCY_EN
//     defined   -> pixels whose ROM value equals TRANS_KEY are not written
//     undefined -> every in-bounds pixel is written
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_src_base               ROM address of sprite pixel (0,0), row stride = cmd_w
//   cmd_dst_x / cmd_dst_y      framebuffer position of sprite pixel (0,0)
//   cmd_w / cmd_h              sprite size in pixels
//   rom_addr / rom_data        sprite ROM read port (data valid same cycle)
//   fb_we / fb_addr / fb_data  registered framebuffer write port
//   busy                       high from the cycle after accept through DONE
//   done                       one-cycle completion pulse
module sprite_blit_writer #(
  parameter int                ADDR_W    = 19,
  parameter int                PIX_W     = 5,
  parameter int                FB_WIDTH  = 320,
  parameter int                FB_HEIGHT = 240,
  parameter logic [PIX_W-1:0]  TRANS_KEY = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [9:0]        cmd_dst_x,
  input  logic [9:0]        cmd_dst_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic              busy,
  output logic              done
);

`ifdef BLIT_TRANSPARENCY_EN
  localparam bit SKIP_KEY = 1'b1;
`else
  localparam bit SKIP_KEY = 1'b0;
`endif

  localparam logic [10:0]       FB_W11 = 11'(FB_WIDTH);
  localparam logic [10:0]       FB_H11 = 11'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        w_q, w_d;
  logic [9:0]        h_q, h_d;
  logic [9:0]        dst_x_q, dst_x_d;
  logic [9:0]        dst_y_q, dst_y_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;   // fb address of the presented pixel
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]  fb_data_q, fb_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic [10:0]       x11, y11;
  logic              in_bounds, pix_skip, last_col, last_row;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    col_d       = col_q;
    row_d       = row_q;
    rom_addr_d  = rom_addr_q;
    pix_addr_d  = pix_addr_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;

    // 11-bit sums so a destination near 1023 cannot wrap back on-screen
    x11       = {1'b0, dst_x_q} + {1'b0, col_q};
    y11       = {1'b0, dst_y_q} + {1'b0, row_q};
    in_bounds = (x11 < FB_W11) && (y11 < FB_H11);
    pix_skip  = SKIP_KEY && (rom_data == TRANS_KEY);
    last_col  = (col_q == w_q - 10'd1);
    last_row  = (row_q == h_q - 10'd1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          w_d        = cmd_w;
          h_d        = cmd_h;
          dst_x_d    = cmd_dst_x;
          dst_y_d    = cmd_dst_y;
          col_d      = '0;
          row_d      = '0;
          rom_addr_d = cmd_src_base;
          // Constant-coefficient product, evaluated once per command only
          pix_addr_d = ADDR_W'(cmd_dst_y) * FB_W_A + ADDR_W'(cmd_dst_x);
          state_d    = (cmd_w == 10'd0 || cmd_h == 10'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        fb_we_d = in_bounds && !pix_skip;
        if (fb_we_d) begin
          fb_addr_d = pix_addr_q;
          fb_data_d = rom_data;
        end
        if (last_col && last_row) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + ONE_A;
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + 10'd1;
            pix_addr_d = pix_addr_q + FB_W_A - ADDR_W'(w_q) + ONE_A;
          end else begin
            col_d      = col_q + 10'd1;
            pix_addr_d = pix_addr_q + ONE_A;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rom_addr_q  <= '0;
      pix_addr_q  <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rom_addr_q  <= rom_addr_d;
      pix_addr_q  <= pix_addr_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rom_addr  = rom_addr_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_blit_writer.sv
// tb_sprite_blit_writer
//   Directed and randomized blits against a per-pixel reference model that
//   derives every expected write from the sprite geometry directly.
module tb_sprite_blit_writer;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 5;
  localparam int FBW    = 320;
  localparam int FBH    = 240;
  localparam int AMASK  = (1 << ADDR_W) - 1;

`ifdef BLIT_TRANSPARENCY_EN
  localparam bit TB_TRANS = 1'b1;
`else
  localparam bit TB_TRANS = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src_base;
  logic [9:0]        cmd_dst_x, cmd_dst_y, cmd_w, cmd_h;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              busy, done;

  logic [PIX_W-1:0]  rom [0:1023];
  assign rom_data = rom[rom_addr[9:0]];

  sprite_blit_writer #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .TRANS_KEY(5'd0)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_base(cmd_src_base), .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y),
    .cmd_w(cmd_w), .cmd_h(cmd_h),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int exp_last_addr = 0;
  int exp_last_data = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pixel_written(input int dx, input int dy, input int c, input int r,
                                       input int pix);
    return (dx + c < FBW) && (dy + r < FBH) && !(TB_TRANS && pix == 0);
  endfunction

  task automatic drive_cmd(input int base, input int dx, input int dy, input int w, input int h);
    cmd_src_base = ADDR_W'(base);
    cmd_dst_x    = dx[9:0];
    cmd_dst_y    = dy[9:0];
    cmd_w        = w[9:0];
    cmd_h        = h[9:0];
  endtask

  // Issues one command and checks every cycle up to the return to idle
  task automatic run_blit(input string name, input int base, input int dx, input int dy,
                          input int w, input int h);
    int k, npix, p, r, c, pix, we, addr;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    check({name, " ready_at_issue"}, cmd_ready, 1);
    drive_cmd(base, dx, dy, w, h);
    cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    npix = w * h;
    for (int i = 1; i <= npix + 2; i++) begin
      @(negedge Clk);
      if (i - 1 < npix)
        check({name, " rom_addr"}, rom_addr, (base + i - 1) & AMASK);
      check({name, " busy"}, busy, (i <= npix + 1) ? 1 : 0);
      check({name, " done"}, done, (i == npix + 1) ? 1 : 0);
      check({name, " cmd_ready"}, cmd_ready, (i == npix + 2) ? 1 : 0);
      p  = i - 2;
      we = 0;
      if (p >= 0 && p < npix) begin
        r    = p / w;
        c    = p % w;
        pix  = int'(rom[(base + p) % 1024]);
        addr = ((dy + r) * FBW + dx + c) & AMASK;
        if (pixel_written(dx, dy, c, r, pix)) begin
          we            = 1;
          exp_last_addr = addr;
          exp_last_data = pix;
        end
      end
      check({name, " fb_we"}, fb_we, we);
      check({name, " fb_addr"}, fb_addr, exp_last_addr);
      check({name, " fb_data"}, fb_data, exp_last_data);
    end
  endtask

  initial begin
    int writes, p, pix;
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) rom[i] = '0;

    // reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst fb_we", fb_we, 0);
    check("rst fb_addr", fb_addr, 0);
    check("rst fb_data", fb_data, 0);
    check("rst rom_addr", rom_addr, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst cmd_ready", cmd_ready, 1);

    // 2x2 at origin
    rom[0] = 5'd1; rom[1] = 5'd2; rom[2] = 5'd3; rom[3] = 5'd4;
    run_blit("t1", 0, 0, 0, 2, 2);

    // right-edge clip
    for (int i = 10; i < 14; i++) rom[i] = 5'd7;
    run_blit("t2", 10, 318, 5, 4, 1);

    // transparency key values
    rom[0] = 5'd0; rom[1] = 5'd9; rom[2] = 5'd0; rom[3] = 5'd9;
    run_blit("t3", 0, 0, 0, 4, 1);

    // zero-size commands
    run_blit("t4", 0, 0, 0, 0, 5);
    run_blit("t4b", 0, 0, 0, 3, 0);

    // 10-bit wrap of dst_x+c must still clip; bottom row clip
    for (int i = 100; i < 110; i++) rom[i] = 5'($urandom_range(1, 31));
    run_blit("wrap_x", 100, 1022, 3, 3, 1);
    run_blit("clip_y", 100, 7, 239, 2, 2);

    // reset in the middle of a 4x4 blit
    for (int i = 0; i < 16; i++) rom[i] = 5'($urandom_range(1, 31));
    drive_cmd(0, 0, 0, 4, 4);
    cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clk);
      p = i - 2;
      if (p >= 0) begin
        pix           = int'(rom[p]);
        exp_last_addr = p;
        exp_last_data = pix;
      end
      check("mid_rst fb_we", fb_we, (p >= 0) ? 1 : 0);
      check("mid_rst fb_addr", fb_addr, exp_last_addr);
      check("mid_rst fb_data", fb_data, exp_last_data);
    end
    Reset = 1'b1;
    exp_last_addr = 0;
    exp_last_data = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      check("in_rst fb_we", fb_we, 0);
      check("in_rst done", done, 0);
      check("in_rst busy", busy, 0);
      check("in_rst cmd_ready", cmd_ready, 0);
      check("in_rst fb_addr", fb_addr, 0);
    end
    Reset = 1'b0;
    writes = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      if (fb_we === 1'b1 || done === 1'b1) writes++;
    end
    check("after_rst quiet", writes, 0);
    check("after_rst cmd_ready", cmd_ready, 1);
    rom[50] = 5'd17;
    run_blit("after_rst 1x1", 50, 3, 4, 1, 1);

    // command held valid while busy is not queued; the new one waits for idle
    rom[20] = 5'd11; rom[21] = 5'd12; rom[40] = 5'd13;
    drive_cmd(20, 10, 10, 2, 1);
    cmd_valid = 1'b1;
    @(posedge Clk);
    writes = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clk);
      if (i == 1) drive_cmd(40, 50, 50, 1, 1);
      if (i == 5) cmd_valid = 1'b0;
      if (fb_we === 1'b1) writes++;
      check("hold cmd_ready", cmd_ready, (i == 4 || i >= 7) ? 1 : 0);
      check("hold done", done, (i == 3 || i == 6) ? 1 : 0);
      check("hold fb_we", fb_we, (i == 2 || i == 3 || i == 6) ? 1 : 0);
      if (i == 2) check("hold addr0", fb_addr, 10 * FBW + 10);
      if (i == 3) check("hold data1", fb_data, 12);
      if (i == 6) check("hold addr_b", fb_addr, 50 * FBW + 50);
      if (i == 6) check("hold data_b", fb_data, 13);
    end
    check("hold write_count", writes, 3);
    exp_last_addr = 50 * FBW + 50;
    exp_last_data = 13;

    // randomized blits around the framebuffer edges
    for (int n = 0; n < 12; n++) begin
      int w, h, dx, dy, base;
      for (int i = 0; i < 1024; i++) rom[i] = 5'($urandom_range(0, 31));
      w    = $urandom_range(0, 5);
      h    = $urandom_range(0, 4);
      dx   = ($urandom_range(0, 3) == 0) ? $urandom_range(1015, 1023) : $urandom_range(300, 330);
      dy   = $urandom_range(225, 245);
      base = $urandom_range(0, 1000);
      run_blit("rand", base, dx, dy, w, h);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
